// File: rtl/flag_branch_unit_pkg.sv
// Shared types for the flag register / branch resolution unit.
// Flag bit positions, condition codes and FSM states.
package flag_branch_unit_pkg;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef logic [2:0] flags_t;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_UN = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  function automatic flags_t merge_flags(
    input flags_t cur,
    input flags_t val,
    input flags_t mask
  );
    return (cur & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle between EX / issue / fetch and the flag-branch unit.
// master drives requests and results, slave is the unit.
interface flag_branch_unit_if #(
  parameter int CW = 2
);
  logic          issue_fw;
  logic          issue_ready;
  logic          ex_valid;
  logic [2:0]    ex_flag;
  logic [2:0]    ex_flag_write;
  logic          flush;
  logic          br_req;
  logic [2:0]    br_cond;
  logic          br_ack;
  logic          br_taken;
  logic [2:0]    flags_out;
  logic [CW-1:0] pending;

  modport master (
    output issue_fw,
    output ex_valid,
    output ex_flag,
    output ex_flag_write,
    output flush,
    output br_req,
    output br_cond,
    input  issue_ready,
    input  br_ack,
    input  br_taken,
    input  flags_out,
    input  pending
  );

  modport slave (
    input  issue_fw,
    input  ex_valid,
    input  ex_flag,
    input  ex_flag_write,
    input  flush,
    input  br_req,
    input  br_cond,
    output issue_ready,
    output br_ack,
    output br_taken,
    output flags_out,
    output pending
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator: (cond, {N,V,Z}) -> taken.
// Shared with the decoder, so it carries no state.
module branch_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  cond_e  cond,
  input  flags_t flags,
  output logic   taken
);

  logic n;
  logic v;
  logic z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_GT: taken = ~z & ~n;
      COND_LT: taken = n;
      COND_GE: taken = z | ~n;
      COND_LE: taken = z | n;
      COND_OV: taken = v;
      COND_UN: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register with in-flight tracking and
// a handshaked conditional-branch resolver that never uses stale flags.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter bit BYPASS       = 1'b1
) (
  input logic               clk,
  input logic               rst,
  flag_branch_unit_if.slave bus
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  flags_t        flags_q;
  flags_t        flags_m;
  flags_t        eval_flags;
  logic [CW-1:0] pend_q;
  logic          retire;
  logic          accept;
  logic          dec;
  logic          bypass_hit;
  logic          can_resolve;
  logic          cond_taken;
  state_e        state_q;
  state_e        state_d;
  cond_e         cond_q;
  cond_e         cond_d;
  cond_e         cond_sel;
  logic          taken_q;
  logic          taken_d;

  assign retire  = bus.ex_valid & (|bus.ex_flag_write);
  assign accept  = bus.issue_fw & bus.issue_ready;
  assign dec     = retire & (pend_q != '0);
  assign flags_m = bus.ex_valid
                 ? merge_flags(flags_q, bus.ex_flag,
                               bus.ex_flag_write)
                 : flags_q;

  assign bus.issue_ready = (pend_q != MAX_CNT);
  assign bus.flags_out   = flags_q;
  assign bus.pending     = pend_q;

  // flush only clears tracking; a retiring write still commits
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      pend_q  <= '0;
    end else begin
      flags_q <= flags_m;
      if (bus.flush)
        pend_q <= '0;
      else if (accept & ~dec)
        pend_q <= pend_q + ONE_CNT;
      else if (dec & ~accept)
        pend_q <= pend_q - ONE_CNT;
    end
  end

  // last outstanding write retiring now: its result is forwarded
  assign bypass_hit = BYPASS && (pend_q == ONE_CNT) && retire;
  assign eval_flags = bypass_hit ? flags_m : flags_q;

  assign cond_sel = (state_q == ST_IDLE)
                  ? cond_e'(bus.br_cond)
                  : cond_q;

  assign can_resolve = (cond_sel == COND_UN)
                     | (pend_q == '0)
                     | bypass_hit;

  branch_cond_eval u_eval (
    .cond  (cond_sel),
    .flags (eval_flags),
    .taken (cond_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cond_q  <= COND_NE;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.br_req) begin
          cond_d = cond_sel;
          if (can_resolve) begin
            state_d = ST_RESOLVE;
            taken_d = cond_taken;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (can_resolve) begin
          state_d = ST_RESOLVE;
          taken_d = cond_taken;
        end
      end
      ST_RESOLVE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign bus.br_ack   = (state_q == ST_RESOLVE);
  assign bus.br_taken = (state_q == ST_RESOLVE) & taken_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed plus random bench for flag_branch_unit against
// an arithmetic reference model of flags, counter and branch protocol.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic rst;

  flag_branch_unit_if #(.CW(2)) bus ();

  flag_branch_unit #(
    .MAX_INFLIGHT (3),
    .BYPASS       (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [2:0] m_flags;
  int       m_pend;
  bit       m_waiting;
  bit       m_ack;
  int       m_cond;
  bit       m_taken;

  function automatic bit ref_taken(input int c, input bit [2:0] f);
    bit n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit iss, input bit ev,
                      input bit [2:0] fl, input bit [2:0] mk,
                      input bit fls, input bit br,
                      input bit [2:0] bc);
    bit       ret;
    bit       byp;
    bit       ok;
    bit [2:0] mrg;
    int       up;
    int       dn;
    @(negedge clk);
    rst               = r;
    bus.issue_fw      = iss;
    bus.ex_valid      = ev;
    bus.ex_flag       = fl;
    bus.ex_flag_write = mk;
    bus.flush         = fls;
    bus.br_req        = br;
    bus.br_cond       = bc;
    if (r) begin
      m_flags   = 3'b000;
      m_pend    = 0;
      m_waiting = 0;
      m_ack     = 0;
      m_taken   = 0;
    end else begin
      ret = ev && (mk != 0);
      mrg = ev ? ((m_flags & ~mk) | (fl & mk)) : m_flags;
      byp = (m_pend == 1) && ret;
      if (m_ack) begin
        m_ack = 0;
      end else if (!m_waiting && br) begin
        m_cond = int'(bc);
        ok = (m_cond == 7) || (m_pend == 0) || byp;
        if (ok) begin
          m_taken = ref_taken(m_cond, byp ? mrg : m_flags);
          m_ack   = 1;
        end else begin
          m_waiting = 1;
        end
      end else if (m_waiting) begin
        ok = (m_cond == 7) || (m_pend == 0) || byp;
        if (fls) begin
          m_waiting = 0;
        end else if (ok) begin
          m_taken   = ref_taken(m_cond, byp ? mrg : m_flags);
          m_waiting = 0;
          m_ack     = 1;
        end
      end
      up = (iss && m_pend < 3) ? 1 : 0;
      dn = (ret && m_pend > 0) ? 1 : 0;
      m_pend  = fls ? 0 : m_pend + up - dn;
      m_flags = mrg;
    end
    @(posedge clk);
    #1;
    chk("flags_out", 8'(bus.flags_out), 8'(m_flags));
    chk("pending", 8'(bus.pending), 8'(m_pend));
    chk("issue_ready", 8'(bus.issue_ready), 8'(m_pend != 3));
    chk("br_ack", 8'(bus.br_ack), 8'(m_ack));
    chk("br_taken", 8'(bus.br_taken), 8'(m_ack && m_taken));
  endtask

  task automatic idle();
    step(0, 0, 0, 3'b000, 3'b000, 0, 0, 3'b000);
  endtask

  initial begin
    bit       r, iss, ev, fls, br;
    bit [2:0] fl, mk, bc;
    m_cond = 0;
    m_flags = 0;
    m_pend = 0;
    m_waiting = 0;
    m_ack = 0;
    m_taken = 0;

    // reset state
    step(1, 0, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(1, 1, 1, 3'b111, 3'b111, 0, 1, 3'b111);
    chk("reset_flags", 8'(bus.flags_out), 8'h00);
    chk("reset_ready", 8'(bus.issue_ready), 8'h01);

    // unconditional branch acks one cycle after acceptance
    step(0, 0, 0, 3'b000, 3'b000, 0, 1, 3'b111);
    chk("uncond_taken", 8'(bus.br_taken), 8'h01);
    idle();

    // branch waits on a pending write, then resolves via bypass
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 0, 0, 3'b000, 3'b000, 0, 1, 3'b110);
    chk("wait_no_ack", 8'(bus.br_ack), 8'h00);
    step(0, 0, 1, 3'b110, 3'b111, 0, 1, 3'b000);
    chk("ov_taken", 8'(bus.br_taken), 8'h01);
    chk("ov_flags", 8'(bus.flags_out), 8'h06);
    idle();

    // partial write and NE / LE conditions
    step(0, 0, 1, 3'b001, 3'b111, 0, 0, 3'b000);
    step(0, 0, 1, 3'b100, 3'b100, 0, 0, 3'b000);
    chk("partial_flags", 8'(bus.flags_out), 8'h05);
    step(0, 0, 0, 3'b000, 3'b000, 0, 1, 3'b000);
    idle();
    step(0, 0, 0, 3'b000, 3'b000, 0, 1, 3'b101);
    idle();
    step(0, 0, 1, 3'b111, 3'b000, 0, 0, 3'b000);

    // counter saturation and same-cycle issue/retire
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    chk("full_pending", 8'(bus.pending), 8'h03);
    step(0, 0, 1, 3'b000, 3'b010, 0, 0, 3'b000);
    step(0, 1, 1, 3'b000, 3'b010, 0, 0, 3'b000);
    chk("issue_retire", 8'(bus.pending), 8'h02);
    step(0, 1, 1, 3'b010, 3'b010, 0, 0, 3'b000);
    step(0, 0, 1, 3'b000, 3'b001, 0, 0, 3'b000);
    step(0, 0, 1, 3'b000, 3'b001, 0, 0, 3'b000);
    step(0, 0, 1, 3'b000, 3'b001, 0, 0, 3'b000);

    // same-cycle bypass resolves without waiting
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 0, 1, 3'b001, 3'b001, 0, 1, 3'b001);
    chk("bypass_taken", 8'(bus.br_taken), 8'h01);
    idle();

    // flush out of WAIT: no ack, counter cleared
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 1, 0, 3'b000, 3'b000, 0, 1, 3'b010);
    step(0, 0, 0, 3'b000, 3'b000, 0, 1, 3'b010);
    step(0, 0, 0, 3'b000, 3'b000, 1, 0, 3'b000);
    chk("flush_pending", 8'(bus.pending), 8'h00);
    idle();
    chk("flush_no_ack", 8'(bus.br_ack), 8'h00);

    // reset while waiting
    step(0, 1, 0, 3'b000, 3'b000, 0, 0, 3'b000);
    step(0, 0, 1, 3'b111, 3'b110, 0, 1, 3'b011);
    step(0, 0, 0, 3'b000, 3'b000, 0, 1, 3'b011);
    step(1, 0, 0, 3'b000, 3'b000, 0, 1, 3'b011);
    chk("rst_wait_ack", 8'(bus.br_ack), 8'h00);
    idle();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      iss = $urandom_range(0, 2) == 0;
      ev  = $urandom_range(0, 2) == 0;
      fl  = 3'($urandom);
      mk  = 3'($urandom);
      fls = ($urandom_range(0, 19) == 0);
      bc  = 3'($urandom);
      br  = m_waiting ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(r, iss, ev, fl, mk, fls, br, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
